serial_subtractor: RTL

- Bit-serial, multi-cycle subtractor: computes d = a - b - bin on B-bit operands, one bit per clock, LSB first.
- Counterpart to the combinational ripple Adder. It is the subtract direction with a start/done handshake.
- Used where area matters more than latency, and as a cross-check against the parallel Adder datapath in the arithmetic unit.

---
 rtl/serial_subtractor.sv | 92 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first subtractor computing d = a - b - bin over B cycles.
// Ports: clk, rst_n (async active-low), start (accepted when not busy),
//        a/b/bin (captured on accept), busy, done (1-cycle pulse), d, bout, ovf.
module serial_subtractor #(
    parameter int B = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [B-1:0] a,
    input  logic [B-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [B-1:0] d,
    output logic         bout,
    output logic         ovf
);
    localparam int CW = $clog2(B);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [B-1:0]  a_sh;
    logic [B-1:0]  b_sh;
    logic [B-1:0]  r_sh;
    logic          brw;
    logic [CW-1:0] cnt;
    logic          a_msb;
    logic          b_msb;
    logic          x;
    logic          brw_next;
    logic [B-1:0]  r_next;

    assign x        = a_sh[0] ^ b_sh[0] ^ brw;
    assign brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
    assign r_next   = {x, r_sh[B-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_next;
                    brw  <= brw_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(B - 1)) begin
                        d     <= r_next;
                        bout  <= brw_next;
                        // Overflow only possible when operand signs differ; x is the result MSB.
                        ovf   <= (a_msb != b_msb) && (x != a_msb);
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request (DONE gives back-to-back issue).
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        r_sh  <= '0;
                        brw   <= bin;
                        cnt   <= '0;
                        a_msb <= a[B-1];
                        b_msb <= b[B-1];
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
